// File: rtl/video_timing_engine_if.sv
// Staged timing configuration bus for video_timing_engine.
interface video_timing_engine_if #(
    parameter int CW = 13
);
    logic [CW-1:0] cfg_h_active;
    logic [CW-1:0] cfg_h_total;
    logic [CW-1:0] cfg_h_sync_start;
    logic [CW-1:0] cfg_h_sync_end;
    logic [CW-1:0] cfg_v_active;
    logic [CW-1:0] cfg_v_total;
    logic [CW-1:0] cfg_v_sync_start;
    logic [CW-1:0] cfg_v_sync_end;
    logic          cfg_hsync_pol;
    logic          cfg_vsync_pol;
    logic          cfg_update;
    logic          cfg_pending;
    logic          cfg_err;

    modport master (
        output cfg_h_active, cfg_h_total,
        output cfg_h_sync_start, cfg_h_sync_end,
        output cfg_v_active, cfg_v_total,
        output cfg_v_sync_start, cfg_v_sync_end,
        output cfg_hsync_pol, cfg_vsync_pol,
        output cfg_update,
        input  cfg_pending, cfg_err
    );

    modport slave (
        input  cfg_h_active, cfg_h_total,
        input  cfg_h_sync_start, cfg_h_sync_end,
        input  cfg_v_active, cfg_v_total,
        input  cfg_v_sync_start, cfg_v_sync_end,
        input  cfg_hsync_pol, cfg_vsync_pol,
        input  cfg_update,
        output cfg_pending, cfg_err
    );
endinterface

// File: rtl/video_timing_engine.sv
// Video timing generator with double-buffered timing set
// committed only at a frame boundary or while stopped.
module video_timing_engine #(
    parameter int CW               = 13,
    parameter int H_ACTIVE_DEF     = 1280,
    parameter int H_TOTAL_DEF      = 1650,
    parameter int H_SYNC_START_DEF = 1390,
    parameter int H_SYNC_END_DEF   = 1430,
    parameter int V_ACTIVE_DEF     = 720,
    parameter int V_TOTAL_DEF      = 750,
    parameter int V_SYNC_START_DEF = 725,
    parameter int V_SYNC_END_DEF   = 730
) (
    input  logic                  pixel_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    video_timing_engine_if.slave  bus,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  hblank,
    output logic                  vblank,
    output logic [CW-1:0]         pix_x,
    output logic [CW-1:0]         pix_y,
    output logic                  sof,
    output logic                  eol,
    output logic [15:0]           frame_cnt
);

    typedef struct packed {
        logic [CW-1:0] h_active;
        logic [CW-1:0] h_total;
        logic [CW-1:0] h_sync_start;
        logic [CW-1:0] h_sync_end;
        logic [CW-1:0] v_active;
        logic [CW-1:0] v_total;
        logic [CW-1:0] v_sync_start;
        logic [CW-1:0] v_sync_end;
        logic          hsync_pol;
        logic          vsync_pol;
    } timing_t;

    localparam timing_t DEF_SET = '{
        h_active:     CW'(H_ACTIVE_DEF),
        h_total:      CW'(H_TOTAL_DEF),
        h_sync_start: CW'(H_SYNC_START_DEF),
        h_sync_end:   CW'(H_SYNC_END_DEF),
        v_active:     CW'(V_ACTIVE_DEF),
        v_total:      CW'(V_TOTAL_DEF),
        v_sync_start: CW'(V_SYNC_START_DEF),
        v_sync_end:   CW'(V_SYNC_END_DEF),
        hsync_pol:    1'b0,
        vsync_pol:    1'b0
    };

    function automatic logic axis_ok(
        input logic [CW-1:0] a,
        input logic [CW-1:0] s,
        input logic [CW-1:0] e,
        input logic [CW-1:0] t
    );
        return (a != '0) && (a <= s) && (s < e)
            && (e <= t) && (t >= CW'(2));
    endfunction

    timing_t       act;
    timing_t       stg;
    timing_t       cfg_in;
    logic          pending;
    logic          err;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          h_last;
    logic          v_last;
    logic          boundary;
    logic          commit;
    logic          staged_ok;
    logic          h_in_sync;
    logic          v_in_sync;

    assign cfg_in = '{
        h_active:     bus.cfg_h_active,
        h_total:      bus.cfg_h_total,
        h_sync_start: bus.cfg_h_sync_start,
        h_sync_end:   bus.cfg_h_sync_end,
        v_active:     bus.cfg_v_active,
        v_total:      bus.cfg_v_total,
        v_sync_start: bus.cfg_v_sync_start,
        v_sync_end:   bus.cfg_v_sync_end,
        hsync_pol:    bus.cfg_hsync_pol,
        vsync_pol:    bus.cfg_vsync_pol
    };

    assign bus.cfg_pending = pending;
    assign bus.cfg_err     = err;

    // >= keeps the counters self-recovering even if they ever exceed total
    assign h_last    = h >= act.h_total - CW'(1);
    assign v_last    = v >= act.v_total - CW'(1);
    assign boundary  = enable && h_last && v_last;
    assign commit    = pending && !bus.cfg_update
                    && (boundary || !enable);
    assign staged_ok = axis_ok(stg.h_active, stg.h_sync_start,
                               stg.h_sync_end, stg.h_total)
                    && axis_ok(stg.v_active, stg.v_sync_start,
                               stg.v_sync_end, stg.v_total);
    assign h_in_sync = (h >= act.h_sync_start) && (h < act.h_sync_end);
    assign v_in_sync = (v >= act.v_sync_start) && (v < act.v_sync_end);

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            h         <= '0;
            v         <= '0;
            frame_cnt <= '0;
        end else if (!enable) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + CW'(1);
            if (v_last) frame_cnt <= frame_cnt + 16'd1;
        end else begin
            h <= h + CW'(1);
        end
    end

    // A fresh capture always beats a commit on the same cycle
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            act     <= DEF_SET;
            stg     <= DEF_SET;
            pending <= 1'b0;
            err     <= 1'b0;
        end else if (bus.cfg_update) begin
            stg     <= cfg_in;
            pending <= 1'b1;
        end else if (commit) begin
            pending <= 1'b0;
            if (staged_ok) begin
                act <= stg;
                err <= 1'b0;
            end else begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            de     <= 1'b0;
            hblank <= 1'b0;
            vblank <= 1'b0;
            sof    <= 1'b0;
            eol    <= 1'b0;
            pix_x  <= '0;
            pix_y  <= '0;
        end else if (!enable) begin
            hsync  <= ~act.hsync_pol;
            vsync  <= ~act.vsync_pol;
            de     <= 1'b0;
            hblank <= 1'b0;
            vblank <= 1'b0;
            sof    <= 1'b0;
            eol    <= 1'b0;
            pix_x  <= '0;
            pix_y  <= '0;
        end else begin
            hsync  <= h_in_sync ? act.hsync_pol : ~act.hsync_pol;
            vsync  <= v_in_sync ? act.vsync_pol : ~act.vsync_pol;
            de     <= (h < act.h_active) && (v < act.v_active);
            hblank <= h >= act.h_active;
            vblank <= v >= act.v_active;
            sof    <= (h == '0) && (v == '0);
            eol    <= (h == act.h_active - CW'(1))
                   && (v < act.v_active);
            pix_x  <= h;
            pix_y  <= v;
        end
    end

endmodule

// File: tb/tb_video_timing_engine.sv
// Randomised and directed bench for video_timing_engine against
// a frame-index reference model.
module tb_video_timing_engine;
    localparam int CW = 13;
    localparam logic [50:0] RST_VEC = {2'b00, 2'b11, 47'd0};

    typedef struct {
        int ha, hs, he, ht;
        int va, vs, ve, vt;
        bit hp, vp;
    } tset_t;

    logic          pixel_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          hsync, vsync, de, hblank, vblank, sof, eol;
    logic [CW-1:0] pix_x, pix_y;
    logic [15:0]   frame_cnt;
    logic [50:0]   dut_vec;
    logic [50:0]   exp_vec;
    int            n_cmp = 0;
    int            n_bad = 0;

    video_timing_engine_if #(.CW(CW)) bus ();

    video_timing_engine #(.CW(CW)) dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bus       (bus.slave),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .hblank    (hblank),
        .vblank    (vblank),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .sof       (sof),
        .eol       (eol),
        .frame_cnt (frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    assign dut_vec = {bus.cfg_pending, bus.cfg_err, hsync, vsync,
                      de, hblank, vblank, sof, eol,
                      pix_x, pix_y, frame_cnt};

    function automatic tset_t mk(int ha, int hs, int he, int ht,
                                 int va, int vs, int ve, int vt,
                                 bit hp, bit vp);
        tset_t s;
        s.ha = ha; s.hs = hs; s.he = he; s.ht = ht;
        s.va = va; s.vs = vs; s.ve = ve; s.vt = vt;
        s.hp = hp; s.vp = vp;
        return s;
    endfunction

    function automatic bit set_ok(tset_t s);
        return s.ha > 0 && s.ha <= s.hs && s.hs < s.he
            && s.he <= s.ht && s.ht >= 2
            && s.va > 0 && s.va <= s.vs && s.vs < s.ve
            && s.ve <= s.vt && s.vt >= 2;
    endfunction

    function automatic tset_t rand_set();
        tset_t s;
        s.ha = $urandom_range(1, 6);
        s.hs = s.ha + $urandom_range(0, 2);
        s.he = s.hs + $urandom_range(1, 3);
        s.ht = s.he + $urandom_range(0, 3);
        s.va = $urandom_range(1, 6);
        s.vs = s.va + $urandom_range(0, 2);
        s.ve = s.vs + $urandom_range(1, 3);
        s.vt = s.ve + $urandom_range(0, 3);
        s.hp = ($urandom_range(0, 1) == 1);
        s.vp = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 9))
            0: s.he = s.hs;
            1: s.va = 0;
            2: s.vt = s.ve - 1;
            default: ;
        endcase
        return s;
    endfunction

    // Reference model: position is a flat index into the frame
    tset_t cur, stg;
    bit    m_pend, m_err, m_bnd;
    int    m_t, m_fc, m_h, m_v;
    logic  e_hs, e_vs, e_de, e_hb, e_vb, e_sof, e_eol;
    int    e_px, e_py;

    always @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            cur = mk(1280, 1390, 1430, 1650, 720, 725, 730, 750, 0, 0);
            stg = cur;
            m_pend = 0; m_err = 0; m_t = 0; m_fc = 0;
            exp_vec = RST_VEC;
        end else begin
            m_bnd = 0;
            if (enable) begin
                m_h = m_t % cur.ht;
                m_v = m_t / cur.ht;
                e_de = m_h < cur.ha && m_v < cur.va;
                e_hb = m_h >= cur.ha;
                e_vb = m_v >= cur.va;
                e_hs = (m_h >= cur.hs && m_h < cur.he) ? cur.hp : !cur.hp;
                e_vs = (m_v >= cur.vs && m_v < cur.ve) ? cur.vp : !cur.vp;
                e_sof = m_t == 0;
                e_eol = m_h == cur.ha - 1 && m_v < cur.va;
                e_px = m_h;
                e_py = m_v;
                m_bnd = m_t == cur.ht * cur.vt - 1;
                m_t = m_bnd ? 0 : m_t + 1;
                if (m_bnd) m_fc = (m_fc + 1) % 65536;
            end else begin
                e_de = 0; e_hb = 0; e_vb = 0; e_sof = 0; e_eol = 0;
                e_hs = !cur.hp; e_vs = !cur.vp;
                e_px = 0; e_py = 0; m_t = 0;
            end
            if (bus.cfg_update) begin
                stg = mk(int'(bus.cfg_h_active), int'(bus.cfg_h_sync_start),
                         int'(bus.cfg_h_sync_end), int'(bus.cfg_h_total),
                         int'(bus.cfg_v_active), int'(bus.cfg_v_sync_start),
                         int'(bus.cfg_v_sync_end), int'(bus.cfg_v_total),
                         bus.cfg_hsync_pol, bus.cfg_vsync_pol);
                m_pend = 1;
            end else if (m_pend && (m_bnd || !enable)) begin
                m_pend = 0;
                if (set_ok(stg)) begin
                    cur = stg;
                    m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
            exp_vec = {m_pend, m_err, e_hs, e_vs, e_de, e_hb, e_vb,
                       e_sof, e_eol, CW'(e_px), CW'(e_py), 16'(m_fc)};
        end
    end

    task automatic tick();
        @(negedge pixel_clk);
        bus.cfg_update = 1'b0;
    endtask

    task automatic put_cfg(input tset_t s);
        bus.cfg_h_active     = CW'(s.ha);
        bus.cfg_h_sync_start = CW'(s.hs);
        bus.cfg_h_sync_end   = CW'(s.he);
        bus.cfg_h_total      = CW'(s.ht);
        bus.cfg_v_active     = CW'(s.va);
        bus.cfg_v_sync_start = CW'(s.vs);
        bus.cfg_v_sync_end   = CW'(s.ve);
        bus.cfg_v_total      = CW'(s.vt);
        bus.cfg_hsync_pol    = s.hp;
        bus.cfg_vsync_pol    = s.vp;
        bus.cfg_update       = 1'b1;
    endtask

    // Counts from the current tick up to (not including) the next sof
    task automatic run_to_sof(output int len, output int de_n,
                              output int hs_hi);
        len = 0; de_n = 0; hs_hi = 0;
        for (int i = 0; i < 500; i++) begin
            if (de === 1'b1) de_n++;
            if (hsync === 1'b1) hs_hi++;
            tick();
            len++;
            if (sof === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (dut_vec !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset got=%h exp=%h", dut_vec, RST_VEC);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (dut_vec !== RST_VEC) begin
            n_bad++;
            $display("FAIL idle_after_reset got=%h exp=%h", dut_vec, RST_VEC);
        end
    endtask

    task automatic test_default();
        int de_n = 0;
        int hs_lo = 0;
        enable = 1'b1;
        for (int k = 0; k < 3300; k++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL default_cyc k=%0d got=%h exp=%h",
                         k, dut_vec, exp_vec);
            end
            if (k == 0) begin
                n_cmp++;
                if (sof !== 1'b1 || pix_x !== '0 || pix_y !== '0) begin
                    n_bad++;
                    $display("FAIL default_first_sof got=%b/%0d/%0d exp=1/0/0",
                             sof, pix_x, pix_y);
                end
            end
            if (de === 1'b1) de_n++;
            if (hsync === 1'b0) hs_lo++;
        end
        n_cmp++;
        if (de_n != 2560) begin
            n_bad++;
            $display("FAIL default_de_count got=%0d exp=2560", de_n);
        end
        n_cmp++;
        if (hs_lo != 80) begin
            n_bad++;
            $display("FAIL default_hsync_low got=%0d exp=80", hs_lo);
        end
    endtask

    task automatic test_commit();
        int len, de_n, hs_hi;
        put_cfg(mk(6, 7, 9, 10, 5, 6, 7, 8, 0, 0));
        tick();
        n_cmp++;
        if (bus.cfg_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL stage_pending got=%b exp=1", bus.cfg_pending);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (bus.cfg_pending !== 1'b0 || de !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_commit got=%b/%b exp=0/0", bus.cfg_pending, de);
        end
        enable = 1'b1;
        tick();
        run_to_sof(len, de_n, hs_hi);
        n_cmp++;
        if (len != 80 || de_n != 30 || frame_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL frame_a got=%0d/%0d/%0d exp=80/30/1",
                     len, de_n, frame_cnt);
        end
        repeat (30) tick();
        put_cfg(mk(4, 5, 6, 8, 3, 4, 5, 6, 0, 0));
        tick();
        n_cmp++;
        if (bus.cfg_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL midframe_pending got=%b exp=1", bus.cfg_pending);
        end
        run_to_sof(len, de_n, hs_hi);
        n_cmp++;
        if (len != 49 || bus.cfg_pending !== 1'b0 || frame_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL old_timing_tail got=%0d/%b/%0d exp=49/0/2",
                     len, bus.cfg_pending, frame_cnt);
        end
        run_to_sof(len, de_n, hs_hi);
        n_cmp++;
        if (len != 48 || de_n != 12) begin
            n_bad++;
            $display("FAIL frame_b got=%0d/%0d exp=48/12", len, de_n);
        end
        n_cmp++;
        if (dut_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL commit_model got=%h exp=%h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_invalid();
        int len, de_n, hs_hi;
        put_cfg(mk(4, 5, 5, 8, 3, 4, 5, 6, 0, 0));
        tick();
        run_to_sof(len, de_n, hs_hi);
        n_cmp++;
        if (len != 47 || bus.cfg_err !== 1'b1 || bus.cfg_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL invalid_reject got=%0d/%b/%b exp=47/1/0",
                     len, bus.cfg_err, bus.cfg_pending);
        end
        run_to_sof(len, de_n, hs_hi);
        n_cmp++;
        if (len != 48) begin
            n_bad++;
            $display("FAIL invalid_keeps_timing got=%0d exp=48", len);
        end
        put_cfg(mk(4, 5, 6, 8, 3, 4, 5, 6, 0, 0));
        tick();
        run_to_sof(len, de_n, hs_hi);
        n_cmp++;
        if (len != 47 || bus.cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear got=%0d/%b exp=47/0", len, bus.cfg_err);
        end
    endtask

    task automatic test_polarity();
        int len, de_n, hs_hi;
        put_cfg(mk(6, 8, 11, 12, 3, 4, 5, 6, 1, 0));
        tick();
        run_to_sof(len, de_n, hs_hi);
        n_cmp++;
        if (hsync !== 1'b0 || bus.cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL pol_idle got=%b/%b exp=0/0", hsync, bus.cfg_err);
        end
        run_to_sof(len, de_n, hs_hi);
        n_cmp++;
        if (len != 72 || hs_hi != 18 || de_n != 18) begin
            n_bad++;
            $display("FAIL pol_frame got=%0d/%0d/%0d exp=72/18/18",
                     len, hs_hi, de_n);
        end
    endtask

    task automatic test_enable();
        repeat (2) tick();
        enable = 1'b0;
        tick();
        n_cmp++;
        if ({de, hsync, vsync, sof, eol} !== 5'b00100 || pix_x !== '0) begin
            n_bad++;
            $display("FAIL disable_idle got=%b%b%b%b%b exp=00100",
                     de, hsync, vsync, sof, eol);
        end
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL disable_model got=%h exp=%h", dut_vec, exp_vec);
        end
        enable = 1'b1;
        tick();
        n_cmp++;
        if (sof !== 1'b1 || de !== 1'b1 || pix_x !== '0 || pix_y !== '0) begin
            n_bad++;
            $display("FAIL reenable_sof got=%b/%b/%0d/%0d exp=1/1/0/0",
                     sof, de, pix_x, pix_y);
        end
    endtask

    task automatic test_back_to_back();
        int len, de_n, hs_hi;
        put_cfg(mk(4, 5, 6, 8, 3, 4, 5, 6, 0, 0));
        tick();
        enable = 1'b0;
        put_cfg(mk(2, 3, 4, 5, 2, 2, 3, 4, 0, 0));
        tick();
        n_cmp++;
        if (bus.cfg_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL update_beats_commit got=%b exp=1", bus.cfg_pending);
        end
        tick();
        n_cmp++;
        if (bus.cfg_pending !== 1'b0 || bus.cfg_err !== 1'b0) begin
            n_bad++;
            $display("FAIL late_commit got=%b/%b exp=0/0",
                     bus.cfg_pending, bus.cfg_err);
        end
        enable = 1'b1;
        tick();
        run_to_sof(len, de_n, hs_hi);
        n_cmp++;
        if (len != 20 || de_n != 4) begin
            n_bad++;
            $display("FAIL last_capture_wins got=%0d/%0d exp=20/4", len, de_n);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6000; k++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL random k=%0d got=%h exp=%h",
                         k, dut_vec, exp_vec);
            end
            enable = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 99) < 3) put_cfg(rand_set());
        end
    endtask

    task automatic test_reset_mid();
        int de_n = 0;
        enable = 1'b1;
        put_cfg(mk(4, 5, 6, 8, 3, 4, 5, 6, 1, 1));
        tick();
        n_cmp++;
        if (bus.cfg_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_pending got=%b exp=1", bus.cfg_pending);
        end
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== RST_VEC) begin
            n_bad++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec, RST_VEC);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 1650; k++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL post_reset k=%0d got=%h exp=%h",
                         k, dut_vec, exp_vec);
            end
            if (de === 1'b1) de_n++;
        end
        n_cmp++;
        if (de_n != 1280 || bus.cfg_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL default_restored got=%0d/%b exp=1280/0",
                     de_n, bus.cfg_pending);
        end
    endtask

    initial begin
        put_cfg(mk(1280, 1390, 1430, 1650, 720, 725, 730, 750, 0, 0));
        bus.cfg_update = 1'b0;
        test_reset();
        test_default();
        test_commit();
        test_invalid();
        test_polarity();
        test_enable();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
